// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile scheduler: command opcodes, FSM
// state encoding, response word layout and a small ceiling-divide helper.
package tpu_pkg;

    // Command opcodes carried on cmd_funct; any value with bit 2 set is illegal.
    localparam logic [2:0] FUNCT_SET_K  = 3'd0;
    localparam logic [2:0] FUNCT_SET_MN = 3'd1;
    localparam logic [2:0] FUNCT_START  = 3'd2;
    localparam logic [2:0] FUNCT_STATUS = 3'd3;

    // Scheduler states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_NEXT  = 2'd3
    } tpu_state_e;

    // Response word layout.
    localparam int RSP_BUSY_BIT = 31;
    localparam int RSP_ERR_BIT  = 30;
    localparam int RSP_DONE_W   = 16;

    // Number of den-sized tiles needed to cover num elements.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/tpu_tile_addr_gen.sv
// Tile loop counters (n_t inner, m_t outer) and base address generation.
// The base addresses are computed from the counter values the next clock
// edge will hold, so the scheduler can register them together with the
// tile_start pulse on the edge that enters ISSUE.
module tpu_tile_addr_gen
    import tpu_pkg::*;
#(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16,
    parameter int ARRAY  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [DIM_W-1:0]  k_i,
    input  logic [DIM_W-1:0]  tm_i,
    input  logic [DIM_W-1:0]  tn_i,
    output logic [ADDR_W-1:0] a_base_o,
    output logic [ADDR_W-1:0] b_base_o,
    output logic [ADDR_W-1:0] c_base_o,
    output logic              last_o
);

    logic [DIM_W-1:0] m_t_q, m_t_d;
    logic [DIM_W-1:0] n_t_q, n_t_d;

    // Next counter values and the tile addresses they select.
    always_comb begin
        m_t_d = m_t_q;
        n_t_d = n_t_q;
        if (clr_i) begin
            m_t_d = '0;
            n_t_d = '0;
        end else if (adv_i) begin
            if (n_t_q == tn_i - DIM_W'(1)) begin
                n_t_d = '0;
                m_t_d = m_t_q + DIM_W'(1);
            end else begin
                n_t_d = n_t_q + DIM_W'(1);
            end
        end
        a_base_o = ADDR_W'(m_t_d) * ADDR_W'(k_i);
        b_base_o = ADDR_W'(n_t_d) * ADDR_W'(k_i);
        c_base_o = (ADDR_W'(m_t_d) * ADDR_W'(tn_i) + ADDR_W'(n_t_d)) * ADDR_W'(ARRAY);
    end

    // The tile currently in flight is the final one of the sweep.
    assign last_o = (m_t_q == tm_i - DIM_W'(1)) && (n_t_q == tn_i - DIM_W'(1));

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t_q <= '0;
            n_t_q <= '0;
        end else begin
            m_t_q <= m_t_d;
            n_t_q <= n_t_d;
        end
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Tile scheduler: accepts CPU commands (every cycle, cmd_ready is tied
// high), answers each accepted command with a one-cycle response strobe on
// the following cycle, and sweeps an M x N output in ARRAY x ARRAY tiles.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// rsp_valid is high for exactly the next cycle with the post-command status.
module tpu_tile_scheduler
    import tpu_pkg::*;
#(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16,
    parameter int ARRAY  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_funct,
    input  logic [31:0]       cmd_op0,
    input  logic [31:0]       cmd_op1,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              tile_start,
    output logic [ADDR_W-1:0] tile_a_base,
    output logic [ADDR_W-1:0] tile_b_base,
    output logic [ADDR_W-1:0] tile_c_base,
    output logic [DIM_W-1:0]  tile_k,
    input  logic              tile_done,
    output logic              busy,
    output logic [1:0]        state_o
);

    tpu_state_e            state_q, state_d;
    logic [DIM_W-1:0]      k_q, m_q, n_q, tm_q, tn_q;
    logic [RSP_DONE_W-1:0] tiles_done_q, tiles_done_d;
    logic                  err_q, err_d;
    logic                  busy_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_data_q, rsp_word;
    logic                  tile_start_q;
    logic [ADDR_W-1:0]     a_base_q, b_base_q, c_base_q;
    logic [DIM_W-1:0]      tile_k_q;

    logic cmd_fire, is_idle, dims_ok, is_set, is_start, illegal;
    logic start_ok, load_k, load_mn, err_set, last_tile;
    logic [DIM_W-1:0]  tm_d, tn_d;
    logic [ADDR_W-1:0] a_nxt, b_nxt, c_nxt;

    // Operand bits above the dimension width carry no meaning.
    logic unused_op_bits;
    assign unused_op_bits = ^{cmd_op0[31:DIM_W], cmd_op1[31:DIM_W]};

    assign cmd_ready = 1'b1;

    tpu_tile_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W),
        .ARRAY  (ARRAY)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_ok),
        .adv_i    (state_q == S_NEXT),
        .k_i      (k_q),
        .tm_i     (tm_q),
        .tn_i     (tn_q),
        .a_base_o (a_nxt),
        .b_base_o (b_nxt),
        .c_base_o (c_nxt),
        .last_o   (last_tile)
    );

    // Command decode, next-state and the status word the response will carry.
    always_comb begin
        cmd_fire = cmd_valid && cmd_ready;
        is_idle  = (state_q == S_IDLE);
        dims_ok  = (k_q != '0) && (m_q != '0) && (n_q != '0);
        is_set   = cmd_fire && ((cmd_funct == FUNCT_SET_K) || (cmd_funct == FUNCT_SET_MN));
        is_start = cmd_fire && (cmd_funct == FUNCT_START);
        illegal  = cmd_fire && cmd_funct[2];
        start_ok = is_start && is_idle && dims_ok;
        load_k   = cmd_fire && (cmd_funct == FUNCT_SET_K) && is_idle;
        load_mn  = cmd_fire && (cmd_funct == FUNCT_SET_MN) && is_idle;
        err_set  = illegal || ((is_set || is_start) && !is_idle) || (is_start && is_idle && !dims_ok);

        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (err_set) begin
            err_d = 1'b1;
        end

        tm_d = DIM_W'(ceil_div(32'(m_q), 32'(ARRAY)));
        tn_d = DIM_W'(ceil_div(32'(n_q), 32'(ARRAY)));

        state_d      = state_q;
        tiles_done_d = tiles_done_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d      = S_ISSUE;
                    tiles_done_d = '0;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (tile_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                tiles_done_d = tiles_done_q + RSP_DONE_W'(1);
                state_d      = last_tile ? S_IDLE : S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase

        rsp_word                   = '0;
        rsp_word[RSP_BUSY_BIT]     = (state_d != S_IDLE);
        rsp_word[RSP_ERR_BIT]      = err_d;
        rsp_word[RSP_DONE_W-1:0]   = tiles_done_d;
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            m_q          <= '0;
            n_q          <= '0;
            tm_q         <= '0;
            tn_q         <= '0;
            tiles_done_q <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            tile_start_q <= 1'b0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            c_base_q     <= '0;
            tile_k_q     <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != S_IDLE);
            err_q        <= err_d;
            tiles_done_q <= tiles_done_d;
            if (load_k) begin
                k_q <= cmd_op0[DIM_W-1:0];
            end
            if (load_mn) begin
                m_q <= cmd_op0[DIM_W-1:0];
                n_q <= cmd_op1[DIM_W-1:0];
            end
            if (start_ok) begin
                tm_q <= tm_d;
                tn_q <= tn_d;
            end
            tile_start_q <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) begin
                a_base_q <= a_nxt;
                b_base_q <= b_nxt;
                c_base_q <= c_nxt;
                tile_k_q <= k_q;
            end
            rsp_valid_q <= cmd_fire;
            if (cmd_fire) begin
                rsp_data_q <= rsp_word;
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign tile_start  = tile_start_q;
    assign tile_a_base = a_base_q;
    assign tile_b_base = b_base_q;
    assign tile_c_base = c_base_q;
    assign tile_k      = tile_k_q;
    assign busy        = busy_q;
    assign state_o     = state_q;

endmodule

// File: doc/tpu_tile_scheduler.md
TPU_TILE_SCHEDULER -- requirements
Module: tpu_tile_scheduler

Interface
REQ-001 SHALL have parameter DIM_W, default 8, which sets the width of the K/M/N dimension registers.
REQ-002 SHALL have parameter ADDR_W, default 16, which sets the width of the buffer addresses.
REQ-003 SHALL have parameter ARRAY, default 4, which sets the systolic array edge (rows and columns per tile).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit: CPU command present.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_funct, input, 3 bits: opcode; 0 SET_K, 1 SET_MN, 2 START, 3 STATUS, others illegal.
REQ-009 SHALL have port cmd_op0, input, 32 bits: operand 0; [DIM_W-1:0] = K for SET_K, M for SET_MN.
REQ-010 SHALL have port cmd_op1, input, 32 bits: operand 1; [DIM_W-1:0] = N for SET_MN.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-012 SHALL have port rsp_data, output, 32 bits: response word; bit31 busy, bit30 err, [15:0] tiles_done.
REQ-013 SHALL have port tile_start, output, 1 bit: one-cycle pulse launching one ARRAYxARRAY tile on the TPU.
REQ-014 SHALL have port tile_a_base, output, ADDR_W bits: A buffer start index for the tile.
REQ-015 SHALL have port tile_b_base, output, ADDR_W bits: B buffer start index for the tile.
REQ-016 SHALL have port tile_c_base, output, ADDR_W bits: C buffer start index for the tile.
REQ-017 SHALL have port tile_k, output, DIM_W bits: reduction length for the tile.
REQ-018 SHALL have port tile_done, input, 1 bit: TPU finished the current tile, including its C writeback.
REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 SHALL hold cmd_ready at 1 in all states.
REQ-021 SHALL assert rsp_valid exactly one cycle after every accepted command, with rsp_data reflecting state after that command.
REQ-022 SHALL, on SET_K or SET_MN in IDLE, load the K, or the M and N, registers; when busy it SHALL leave the registers unchanged and set err.
REQ-023 SHALL implement states IDLE, ISSUE, WAIT and NEXT: IDLE->ISSUE on accepted START with K, M and N all nonzero; ISSUE->WAIT unconditionally; WAIT->NEXT on tile_done; NEXT->ISSUE if tiles remain, else NEXT->IDLE.
REQ-024 SHALL compute TM = ceil(M/ARRAY) and TN = ceil(N/ARRAY) at START and clear tile counters m_t, n_t and tiles_done.
REQ-025 SHALL make n_t the inner loop: in NEXT, n_t increments; when n_t wraps from TN-1 to 0, m_t increments.
REQ-026 SHALL pulse tile_start for exactly the ISSUE cycle, with tile_a_base = m_t*K, tile_b_base = n_t*K, tile_c_base = (m_t*TN+n_t)*ARRAY and tile_k = K, all held stable from ISSUE through WAIT.
REQ-027 SHALL, with START accepted at cycle T, assert the first tile_start at T+1; with tile_done at cycle D, issue the next tile_start at D+2, or drop busy at D+2 after the last tile.
REQ-028 SHALL ignore tile_done outside WAIT.
REQ-029 SHALL increment tiles_done (16-bit) in NEXT.
REQ-030 SHALL, on START with K, M or N equal to 0, stay in IDLE, set err and issue no tile.
REQ-031 SHALL, on START or SET_* while busy, set err with no effect on the running sequence.
REQ-032 SHALL clear err on the next accepted legal START in IDLE.
REQ-033 SHALL set err on an illegal funct (4 to 7) and still respond.
REQ-034 SHALL perform address arithmetic unsigned, truncated to ADDR_W.

Reset
REQ-035 SHALL, on rst_n low, immediately enter IDLE and clear K, M, N, m_t, n_t, tiles_done, err, rsp_valid, rsp_data, tile_start, all tile_* buses and busy, including mid-sequence.
REQ-036 SHALL leave cmd_ready at 1 after reset deassertion.

Structure
REQ-037 SHALL place the funct opcode constants, the state encoding, and the rsp_data bit positions in shared package tpu_pkg.
REQ-038 SHALL use one sub-module, tpu_tile_addr_gen, to hold m_t and n_t and produce the three base addresses.

Verification
REQ-039 SHALL verify: SET_K 4, SET_MN 8/4, START -> 2 tiles with (a, b, c) = (0, 0, 0) then (4, 0, 4); busy drops 2 cycles after the second tile_done; STATUS returns tiles_done = 2.
REQ-040 SHALL verify: K=3, M=5, N=6 -> 4 tiles with a = 0, 0, 3, 3; b = 0, 3, 0, 3; c = 0, 4, 8, 12.
REQ-041 SHALL verify: START with N=0 -> no tile_start; rsp_data bit30 = 1; busy stays 0.
REQ-042 SHALL verify: START then SET_K 9 during WAIT -> err = 1; subsequent tile_k remains the original K.
REQ-043 SHALL verify: tile_done pulsed in IDLE or ISSUE -> ignored; a spurious second tile_done in NEXT -> no skipped tile.
REQ-044 SHALL verify: rst_n low during WAIT of tile 2 -> all outputs 0 asynchronously; a new START after release begins again at tile 0.
